// File: rtl/dram_pkg.sv
// Shared sizing and types for the behavioural DRAM model.
// The row index is the upper slice of the word address.
package dram_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 8;
   localparam int ROW_BITS   = 6;
   localparam int NUM_ROWS   = 2 ** ROW_BITS;
   localparam int COL_BITS   = ADDR_WIDTH - ROW_BITS;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ROW_BITS-1:0]   row_t;

   function automatic row_t row_of(input addr_t a);
      return a[ADDR_WIDTH-1 -: ROW_BITS];
   endfunction

endpackage

// File: rtl/dram_refresh_ctrl.sv
// Per-row charge retention tracking plus a round-robin refresh engine.
// A row loses validity after RETENTION_CYCLES edges without a restore.
module dram_refresh_ctrl
   import dram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 8,
   parameter int RETENTION_CYCLES = 1024,
   parameter bit REFRESH_EN       = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                access,
   input  row_t                access_row,
   input  logic                write,
   output logic [NUM_ROWS-1:0] row_valid
);

   localparam int IW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam int CW = $clog2(RETENTION_CYCLES + 1);
   localparam logic [IW-1:0] IC_LAST  = IW'(REFRESH_INTERVAL - 1);
   localparam logic [CW-1:0] RET_MAX  = CW'(RETENTION_CYCLES);
   localparam logic [CW-1:0] RET_WARN = CW'(RETENTION_CYCLES - 1);

   logic [IW-1:0]       interval_cnt;
   row_t                refresh_ptr;
   logic                refresh_hit;
   logic [CW-1:0]       ret_cnt [NUM_ROWS];
   logic [NUM_ROWS-1:0] restore_vec;
   logic [NUM_ROWS-1:0] write_vec;

   assign refresh_hit = REFRESH_EN && (interval_cnt == IC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         interval_cnt <= '0;
         refresh_ptr  <= '0;
      end else if (interval_cnt == IC_LAST) begin
         interval_cnt <= '0;
         refresh_ptr  <= refresh_ptr + row_t'(1);
      end else begin
         interval_cnt <= interval_cnt + IW'(1);
      end
   end

   // Host access and refresh both restore a row; only a write revalidates it.
   always_comb begin
      restore_vec = '0;
      write_vec   = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         restore_vec[i] = (access && (access_row == row_t'(i))) ||
                          (refresh_hit && (refresh_ptr == row_t'(i)));
         write_vec[i]   = access && write && (access_row == row_t'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ROWS; i++) begin
            ret_cnt[i] <= '0;
         end
         row_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_ROWS; i++) begin
            if (restore_vec[i]) begin
               ret_cnt[i] <= '0;
            end else if (ret_cnt[i] != RET_MAX) begin
               ret_cnt[i] <= ret_cnt[i] + CW'(1);
            end
            if (write_vec[i]) begin
               row_valid[i] <= 1'b1;
            end else if (!restore_vec[i] && (ret_cnt[i] == RET_WARN)) begin
               row_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/dram_model.sv
// 4K x 8 single-port DRAM stand-in: synchronous write-first RAM whose rows
// read back as zero once their charge has decayed.
module dram_model
   import dram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 8,
   parameter int RETENTION_CYCLES = 1024,
   parameter bit REFRESH_EN       = 1'b1
) (
   input  logic  clk,
   input  logic  rst_n,
   input  addr_t address,
   input  data_t data_in,
   input  logic  we,
   output data_t data_out
);

   data_t               mem [2**ADDR_WIDTH];
   row_t                access_row;
   logic [NUM_ROWS-1:0] row_valid;

   assign access_row = row_of(address);

   dram_refresh_ctrl #(
      .REFRESH_INTERVAL(REFRESH_INTERVAL),
      .RETENTION_CYCLES(RETENTION_CYCLES),
      .REFRESH_EN      (REFRESH_EN)
   ) u_refresh (
      .clk       (clk),
      .rst_n     (rst_n),
      .access    (1'b1),
      .access_row(access_row),
      .write     (we),
      .row_valid (row_valid)
   );

   // A write landing on an edge while reset is held must not reach the array.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         mem[address] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
      end else if (we) begin
         data_out <= data_in;
      end else begin
         data_out <= row_valid[access_row] ? mem[address] : '0;
      end
   end

endmodule

// File: tb/tb_dram_model.sv
// Scoreboarded random/directed bench driving a refreshing and a decaying
// instance with identical traffic against a per-row retention-time model.
module tb_dram_model;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] address = '0;
   logic [7:0]  data_in = '0;
   logic        we = 1'b0;
   logic [7:0]  data_out_ref;
   logic [7:0]  data_out_dec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dram_model dut_ref (
      .clk(clk), .rst_n(rst_n), .address(address),
      .data_in(data_in), .we(we), .data_out(data_out_ref)
   );

   dram_model #(.REFRESH_INTERVAL(8), .RETENTION_CYCLES(16), .REFRESH_EN(1'b0)) dut_dec (
      .clk(clk), .rst_n(rst_n), .address(address),
      .data_in(data_in), .we(we), .data_out(data_out_dec)
   );

   // Reference model: instance 0 refreshes with 1024-cycle retention,
   // instance 1 never refreshes and forgets after 16 cycles.
   logic [7:0] m_mem   [2][4096];
   bit         m_valid [2][64];
   int         m_last  [2][64];
   int         m_ret   [2] = '{1024, 16};
   bit         m_ren   [2] = '{1'b1, 1'b0};
   int         edge_n = 0;

   logic [7:0] exp_ref [$];
   logic [7:0] exp_dec [$];
   string      tag_q   [$];

   function automatic void modelReset();
      for (int k = 0; k < 2; k++)
         for (int q = 0; q < 64; q++) begin
            m_valid[k][q] = 1'b0;
            m_last[k][q]  = 0;
         end
      edge_n = 0;
   endfunction

   function automatic logic [7:0] modelStep(int k, int a, bit w, logic [7:0] d, int e);
      int r  = a / 64;
      int rr = -1;
      logic [7:0] rd = m_valid[k][r] ? m_mem[k][a] : 8'h00;
      if (m_ren[k] && (e % 8 == 0)) rr = ((e / 8) - 1) % 64;
      for (int q = 0; q < 64; q++) begin
         if (q == r || q == rr) m_last[k][q] = e;
         else if (m_valid[k][q] && (e - m_last[k][q] >= m_ret[k])) m_valid[k][q] = 1'b0;
      end
      if (w) begin
         m_mem[k][a] = d;
         m_valid[k][r] = 1'b1;
         rd = d;
      end
      return rd;
   endfunction

   function automatic void checkOutput(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // Called at a falling edge; drives one access and returns at the next falling edge.
   task automatic applyStimulus(input int a, input bit w, input logic [7:0] d, input string tag);
      address = 12'(a);
      we      = w;
      data_in = d;
      edge_n++;
      exp_ref.push_back(modelStep(0, a, w, d, edge_n));
      exp_dec.push_back(modelStep(1, a, w, d, edge_n));
      tag_q.push_back(tag);
      @(negedge clk);
   endtask

   task automatic doReset(input string tag);
      rst_n = 1'b0;
      #1;
      checkOutput({tag, " ref"}, data_out_ref, 8'h00);
      checkOutput({tag, " dec"}, data_out_dec, 8'h00);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_ref.size() > 0 && exp_dec.size() > 0 && tag_q.size() > 0) begin
         string t = tag_q.pop_front();
         checkOutput({t, " ref"}, data_out_ref, exp_ref.pop_front());
         checkOutput({t, " dec"}, data_out_dec, exp_dec.pop_front());
      end
   end

   initial begin
      @(negedge clk);
      doReset("reset");

      applyStimulus(12'h000, 1, 8'hAA, "wr000");
      applyStimulus(12'h000, 0, 8'h00, "rd000");
      applyStimulus(12'h123, 0, 8'h00, "rd123_unwritten");
      applyStimulus(12'h123, 1, 8'h55, "wr123");
      applyStimulus(12'h123, 0, 8'h00, "rd123");
      applyStimulus(12'h0FF, 1, 8'h11, "wr0FF");
      applyStimulus(12'h100, 1, 8'h22, "wr100");
      applyStimulus(12'h0FF, 0, 8'h00, "rd0FF");
      applyStimulus(12'h100, 0, 8'h00, "rd100");

      applyStimulus(12'hFFF, 1, 8'h3C, "wrFFF");
      for (int i = 0; i < 2000; i++)
         applyStimulus(int'($urandom_range(0, 12'hFBF)), 0, 8'h00, "rd_other");
      applyStimulus(12'hFFF, 0, 8'h00, "rdFFF_retained");

      applyStimulus(12'h040, 1, 8'h77, "wr040");
      for (int i = 0; i < 20; i++)
         applyStimulus(12'h080 + i, 0, 8'h00, "rd_idle");
      applyStimulus(12'h040, 0, 8'h00, "rd040_decay");

      applyStimulus(12'h040, 1, 8'h77, "wr040_again");
      for (int j = 0; j < 5; j++) begin
         for (int i = 0; i < 9; i++)
            applyStimulus(12'h0C0 + i, 0, 8'h00, "rd_gap");
         applyStimulus(12'h040, 0, 8'h00, "rd040_kept");
      end

      for (int i = 0; i < 1500; i++) begin
         int a = int'($urandom_range(0, 4095)) % 512 + 64 * int'($urandom_range(0, 1) * 56);
         applyStimulus(a, bit'($urandom_range(0, 2) == 0), 8'($urandom), "random");
      end

      applyStimulus(12'h010, 1, 8'h99, "wr010");
      address = 12'h010;
      we      = 1'b1;
      data_in = 8'hEE;
      doReset("midreset");
      applyStimulus(12'h010, 0, 8'h00, "rd010_after_reset");
      applyStimulus(12'h010, 0, 8'h00, "rd010_again");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
